// File: rtl/imm_inst_encoder.sv
// imm_inst_encoder
//   Packs opcode/register fields and a 32-bit immediate into an RV32I instruction
//   word (R/I/S/B/U/J layouts). Also expands the LI pseudo-op into ADDI, LUI, or
//   LUI followed by ADDI. Unencodable requests produce a single NOP_INST word
//   flagged with out_err.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready     request handshake
//   in_fmt                  0=R 1=I 2=S 3=B 4=U 5=J 6=LI 7=reserved
//   in_opcode, in_funct3,
//   in_funct7               instruction fields
//   in_rd, in_rs1, in_rs2   register fields
//   in_imm                  immediate in byte-offset/value form
//   out_valid / out_ready   output handshake
//   out_inst                encoded word (registered)
//   out_last                final beat of the current request
//   out_err                 request was unencodable; out_inst = NOP_INST
module imm_inst_encoder #(
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [6:0]  in_opcode,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_last,
   output logic        out_err
);

   localparam logic [6:0] OpLui  = 7'b0110111;
   localparam logic [6:0] OpImm  = 7'b0010011;
   localparam logic [2:0] F3Addi = 3'b000;

   typedef enum logic [1:0] {StIdle, StBeat, StBeat2} state_e;

   state_e      state_q, state_d;
   logic [31:0] inst_q, beat2_q;
   logic        last_q, err_q;

   logic        accept;
   logic        load_first, load_second;

   // Combinational encoder outputs for the request currently on the input side.
   logic [31:0] enc_inst, enc_beat2;
   logic        enc_last, enc_err;

   logic        fits_i, fits_b, fits_j, is_shift;
   logic [19:0] li_hi;

   //---------------------------------------------------------------------------
   // Encoder
   //---------------------------------------------------------------------------
   always_comb begin
      // Sign-extension range checks: all upper bits equal to the top kept bit.
      fits_i   = (in_imm[31:11] == {21{in_imm[11]}});
      fits_b   = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
      fits_j   = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
      is_shift = (in_opcode == OpImm) && ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
      // Round hi up when lo will be sign-extended negative by ADDI.
      li_hi    = in_imm[31:12] + {19'd0, in_imm[11]};

      enc_inst  = NOP_INST;
      enc_beat2 = '0;
      enc_last  = 1'b1;
      enc_err   = 1'b0;

      case (in_fmt)
         3'd0: enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         3'd1: begin
            if (is_shift) begin
               if (in_imm[31:5] == '0) begin
                  enc_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
               end else begin
                  enc_err = 1'b1;
               end
            end else if (fits_i) begin
               enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            end else begin
               enc_err = 1'b1;
            end
         end
         3'd2: begin
            if (fits_i) begin
               enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            end else begin
               enc_err = 1'b1;
            end
         end
         3'd3: begin
            if (fits_b) begin
               enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
            end else begin
               enc_err = 1'b1;
            end
         end
         3'd4: begin
            if (in_imm[11:0] == '0) begin
               enc_inst = {in_imm[31:12], in_rd, in_opcode};
            end else begin
               enc_err = 1'b1;
            end
         end
         3'd5: begin
            if (fits_j) begin
               enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd,
                           in_opcode};
            end else begin
               enc_err = 1'b1;
            end
         end
         3'd6: begin
            if (li_hi == '0) begin
               enc_inst = {in_imm[11:0], 5'd0, F3Addi, in_rd, OpImm};
            end else if (in_imm[11:0] == '0) begin
               enc_inst = {li_hi, in_rd, OpLui};
            end else begin
               enc_inst  = {li_hi, in_rd, OpLui};
               enc_beat2 = {in_imm[11:0], in_rd, F3Addi, in_rd, OpImm};
               enc_last  = 1'b0;
            end
         end
         default: enc_err = 1'b1;
      endcase
   end

   //---------------------------------------------------------------------------
   // FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   //---------------------------------------------------------------------------
   // FSM: next state
   //---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      load_first  = 1'b0;
      load_second = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d    = StBeat;
               load_first = 1'b1;
            end
         end
         StBeat: begin
            if (out_ready) begin
               if (!last_q) begin
                  state_d     = StBeat2;
                  load_second = 1'b1;
               end else if (accept) begin
                  load_first = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StBeat2: begin
            if (out_ready) begin
               if (accept) begin
                  state_d    = StBeat;
                  load_first = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   //---------------------------------------------------------------------------
   // FSM: outputs
   //---------------------------------------------------------------------------
   always_comb begin
      out_valid = (state_q != StIdle);
      in_ready  = !out_valid || (out_ready && last_q);
      accept    = in_valid && in_ready;
      out_inst  = inst_q;
      out_last  = last_q;
      out_err   = err_q;
   end

   //---------------------------------------------------------------------------
   // Output word registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q  <= '0;
         beat2_q <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (load_first) begin
         inst_q  <= enc_inst;
         beat2_q <= enc_beat2;
         last_q  <= enc_last;
         err_q   <= enc_err;
      end else if (load_second) begin
         inst_q <= beat2_q;
         last_q <= 1'b1;
         err_q  <= 1'b0;
      end
   end

endmodule

// File: doc/imm_inst_encoder.md
Name: imm_inst_encoder

Overview:
- Instruction encoder: packs opcode/register fields plus a 32-bit immediate into a 32-bit RV32I instruction word, scattering immediate bits into R/I/S/B/U/J layouts.
- Also expands the LI pseudo-op into ADDI, LUI, or LUI+ADDI.
- Feeds the test-program loader and self-check stimulus path ahead of IF/ID.
- Valid/ready handshake on both sides, registered output.

Parameters:
- NOP_INST, 32'h00000013, word emitted in place of an unencodable request.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J 6=LI 7=reserved
- in_opcode  input  7  opcode field (ignored for LI)
- in_funct3  input  3  funct3 (ignored for U/J/LI)
- in_funct7  input  7  funct7 (R, and I-shift upper bits)
- in_rd  input  5  destination register
- in_rs1  input  5  source 1
- in_rs2  input  5  source 2
- in_imm  input  32  immediate, byte-offset/value form
- out_valid  output  1  output word valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_inst  output  32  encoded instruction
- out_last  output  1  final beat of current request
- out_err  output  1  request unencodable; out_inst = NOP_INST

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, out_inst=0, out_last=0, out_err=0. Reset mid-request discards any pending second LI beat.
- Handshake:
  - in_ready = !out_valid || (out_ready && out_last); combinational from out_ready.
  - Accepted request produces its first beat on the next cycle (latency 1).
  - Throughput is 1 word/cycle under continuous out_ready.
  - While out_valid && !out_ready: out_inst, out_last and out_err hold stable.
- FSM: IDLE -> BEAT (first word held) -> BEAT2 (LI second word) -> IDLE/BEAT.
  - BEAT with out_last=0 moves to BEAT2 on out_ready.
  - Final beat consumed with a new request accepted in the same cycle -> BEAT.
  - Final beat consumed with no new request -> IDLE.
- Encodings (imm = in_imm):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}. Legal iff imm[31:11] all equal.
  - I-shift (opcode 0010011, funct3 001/101): {funct7, imm[4:0], rs1, funct3, rd, opcode}. Legal iff imm[31:5]==0.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. Legal iff imm[31:11] all equal.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. Legal iff imm[0]==0 and imm[31:12] all equal.
  - U: {imm[31:12], rd, opcode}. Legal iff imm[11:0]==0.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}. Legal iff imm[0]==0 and imm[31:20] all equal.
- Illegal immediate or fmt=7: single beat, out_inst=NOP_INST, out_err=1, out_last=1.
- LI expansion:
  - lo = imm[11:0]; hi = imm[31:12] + imm[11], mod 2^20.
  - hi==0: one beat ADDI rd,x0,lo.
  - hi!=0 and imm[11:0]==0: one beat LUI rd,hi.
  - Otherwise: beat1 LUI rd,hi (out_last=0), beat2 ADDI rd,rd,lo (out_last=1).
  - LUI opcode 0110111; ADDI opcode 0010011, funct3 000.
  - rd=0 is encoded normally (no error). out_err=0 always for LI.
- out_last=1 on every single-beat word.

Test Plan:
- LI rd=5 imm=0x12345678 -> beat1 0x123452B7 last=0, beat2 0x67828293 last=1.
- LI rd=1 imm=0x00000800 (carry case) -> 0x000010B7, then 0x80008093.
- LI rd=10 imm=0xFFFFFFFF -> single 0xFFF00513 last=1; LI rd=2 imm=0x00003000 -> single 0x00003137.
- B opcode 1100011 f3=0 rs1=1 rs2=2 imm=0xFFFFFFF8 -> 0xFE208CE3 err=0; same request with imm=3 -> 0x00000013 err=1 last=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles on LI beat1 -> out_inst stable, in_ready=0.
  - Then 4 back-to-back I requests with out_ready=1 -> one word per cycle, no gaps.
- Assert rst_n=0 while LI beat1 is stalled -> out_valid/out_inst/out_last/out_err=0 immediately; after release, no beat2 is emitted.
